// File: rtl/gpu_alu_pkg.sv
// Shared GPU ALU definitions for the ALU3 digit sequencer.
//   OP_W / DIGIT_W : one-hot opcode width and BCD digit width seen by ALU3
//   seq_state_e    : sequencer state encoding
//   onehot()       : index -> one-hot opcode
//   popcount()     : count of set bits in an opcode-wide vector
package gpu_alu_pkg;

  localparam int unsigned OP_W    = 16;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned IDX_W   = $clog2(OP_W);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StSample,
    StDone
  } seq_state_e;

  function automatic logic [OP_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    return OP_W'(1) << idx;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [OP_W-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < OP_W; i++) begin
      c = c + (IDX_W + 1)'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/alu3_digit_sequencer_if.sv
// ALU3 compare bus between the digit sequencer (master) and ALU3 (slave).
//   a_out      : operand A to ALU3
//   op_dec     : one-hot opcode to ALU3 OpDec
//   student_id : current ID digit to ALU3
//   ans_in     : ALU3 Ans back to the sequencer
interface alu3_digit_sequencer_if;
  import gpu_alu_pkg::*;

  logic [7:0]         a_out;
  logic [OP_W-1:0]    op_dec;
  logic [DIGIT_W-1:0] student_id;
  logic [3:0]         ans_in;

  modport master (
    output a_out,
    output op_dec,
    output student_id,
    input  ans_in
  );

  modport slave (
    input  a_out,
    input  op_dec,
    input  student_id,
    output ans_in
  );

endinterface

// File: rtl/alu3_digit_sequencer.sv
// ALU3 ID-match sequencer. On start, walks the latched student-ID digits one at a time: each digit
// gets an ISSUE (settle) cycle and a SAMPLE cycle, after which ALU3's Ans[0] is stored in match_vec.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, abort            : scan request (IDLE only) / synchronous cancel of a running scan
//   a_in, id_digits         : operand A and digits, latched at start (digit i = id_digits[i*4 +: 4])
//   alu                     : ALU3 bus (a_out, op_dec, student_id out; ans_in in)
//   busy, done              : scanning / one-cycle completion pulse
//   match_vec, match_count  : per-digit results and their popcount
//   any_match, err          : OR of match_vec / sticky flag for nonzero ans_in[3:1] at a sample
module alu3_digit_sequencer
  import gpu_alu_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [7:0]                    a_in,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] id_digits,
  alu3_digit_sequencer_if.master        alu,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_DIGITS-1:0]         match_vec,
  output logic [3:0]                    match_count,
  output logic                          any_match,
  output logic                          err
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_DIGITS - 1);

  seq_state_e state_q, state_d;

  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [7:0]                    a_q, a_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]         match_q, match_d;
  logic                          err_q, err_d;
  logic [3:0]                    count_q, count_d;
  logic                          any_q, any_d;
  logic [OP_W-1:0]               op_dec_q, op_dec_d;
  logic [DIGIT_W-1:0]            sid_q, sid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          scanning_d;
  logic [IDX_W:0]                pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats start and beats the sample of the current digit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start && !abort) state_d = StIssue;
      StIssue:  state_d = abort ? StIdle : StSample;
      StSample: begin
        if (abort)                state_d = StIdle;
        else if (idx_q == LastIdx) state_d = StDone;
        else                       state_d = StIssue;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    digits_d = digits_q;
    match_d  = match_q;
    err_d    = err_q;

    if (state_q == StIdle && state_d == StIssue) begin
      idx_d    = '0;
      a_d      = a_in;
      digits_d = id_digits;
      match_d  = '0;
      err_d    = 1'b0;
    end

    if (state_q == StSample && !abort) begin
      match_d[idx_q] = alu.ans_in[0];
      err_d          = err_q | (|alu.ans_in[3:1]);
      if (state_d == StIssue) idx_d = idx_q + IDX_W'(1);
    end

    scanning_d = (state_d == StIssue) || (state_d == StSample);
    // digits_d already holds the freshly latched digits on the start edge
    op_dec_d   = scanning_d ? onehot(idx_d) : '0;
    sid_d      = scanning_d ? digits_d[idx_d*DIGIT_W +: DIGIT_W] : '0;
    busy_d     = scanning_d;
    done_d     = (state_d == StDone);

    pc      = popcount(OP_W'(match_d));
    count_d = pc[3:0];
    any_d   = |match_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      a_q      <= '0;
      digits_q <= '0;
      match_q  <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
      any_q    <= 1'b0;
      op_dec_q <= '0;
      sid_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      digits_q <= digits_d;
      match_q  <= match_d;
      err_q    <= err_d;
      count_q  <= count_d;
      any_q    <= any_d;
      op_dec_q <= op_dec_d;
      sid_q    <= sid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign alu.a_out      = a_q;
  assign alu.op_dec     = op_dec_q;
  assign alu.student_id = sid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign match_vec      = match_q;
  assign match_count    = count_q;
  assign any_match      = any_q;
  assign err            = err_q;

endmodule

// File: tb/tb_alu3_digit_sequencer.sv
// Bench for alu3_digit_sequencer with a behavioural ALU3 responder: Ans[0] is set when the
// current ID digit equals either nibble of A, and Ans is zero when op_dec is zero.
module tb_alu3_digit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  a_in = '0;
  logic [35:0] id_digits = '0;
  logic        busy, done, any_match, err;
  logic [8:0]  match_vec;
  logic [3:0]  match_count;
  int          force_idx = -1;

  int checks = 0;
  int errors = 0;

  alu3_digit_sequencer_if bus ();

  alu3_digit_sequencer #(
    .NUM_DIGITS (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .a_in        (a_in),
    .id_digits   (id_digits),
    .alu         (bus),
    .busy        (busy),
    .done        (done),
    .match_vec   (match_vec),
    .match_count (match_count),
    .any_match   (any_match),
    .err         (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.ans_in = 4'b0000;
    if (|bus.op_dec) begin
      bus.ans_in[0] = (bus.student_id == bus.a_out[7:4]) || (bus.student_id == bus.a_out[3:0]);
      if (force_idx >= 0 && force_idx < 16) begin
        if (bus.op_dec[force_idx]) bus.ans_in = 4'b0011;
      end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [35:0] d;
    logic [8:0]  vec;
    logic [3:0]  cnt;
    logic        any;
  } vec_t;

  vec_t tbl [5];

  localparam logic [35:0] Ids = 36'h987654321;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_opdec"}, 32'(bus.op_dec), 0);
    check({tag, "_sid"}, 32'(bus.student_id), 0);
    check({tag, "_aout"}, 32'(bus.a_out), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_vec"}, 32'(match_vec), 0);
    check({tag, "_cnt"}, 32'(match_count), 0);
    check({tag, "_any"}, 32'(any_match), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Full scan: checks the op_dec walk, student_id, busy, done timing and a_out latching.
  task automatic run_scan(input string tag, input logic [7:0] a, input logic [35:0] d);
    int          done_edge;
    int          pulses;
    logic [15:0] exp_op;
    done_edge = -1;
    pulses    = 0;
    @(negedge clk);
    a_in      = a;
    id_digits = d;
    start     = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) begin
        start     = 1'b0;
        a_in      = ~a;
        id_digits = ~d;
      end
      if (e <= 18) begin
        exp_op = (e < 18) ? (16'(1) << (e / 2)) : 16'h0000;
        check({tag, "_opdec"}, 32'(bus.op_dec), 32'(exp_op));
        check({tag, "_busy"}, 32'(busy), (e < 18) ? 1 : 0);
        if (e < 18) check({tag, "_sid"}, 32'(bus.student_id), 32'(d[(e / 2) * 4 +: 4]));
      end
      if (done) begin
        pulses++;
        if (done_edge < 0) done_edge = e;
      end
    end
    check({tag, "_done_edge"}, 32'(done_edge), 18);
    check({tag, "_done_pulses"}, 32'(pulses), 1);
    check({tag, "_aout"}, 32'(bus.a_out), 32'(a));
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;

    tbl[0] = '{a: 8'h35, d: Ids,          vec: 9'b000010100, cnt: 4'd2, any: 1'b1};
    tbl[1] = '{a: 8'hFF, d: Ids,          vec: 9'h000,       cnt: 4'd0, any: 1'b0};
    tbl[2] = '{a: 8'h77, d: 36'h777777777, vec: 9'h1FF,       cnt: 4'd9, any: 1'b1};
    tbl[3] = '{a: 8'h90, d: Ids,          vec: 9'h100,       cnt: 4'd1, any: 1'b1};
    tbl[4] = '{a: 8'h11, d: 36'h111000001, vec: 9'b111000001, cnt: 4'd4, any: 1'b1};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_scan($sformatf("vec%0d", i), tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d_match_vec", i), 32'(match_vec), 32'(tbl[i].vec));
      check($sformatf("vec%0d_match_count", i), 32'(match_count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d_any", i), 32'(any_match), 32'(tbl[i].any));
      check($sformatf("vec%0d_err", i), 32'(err), 0);
    end

    // Abort during SAMPLE of digit 2: digits 0 and 1 match, digit 2 would match too
    @(negedge clk);
    a_in      = 8'h12;
    id_digits = 36'h987654221;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_pre_opdec", 32'(bus.op_dec), 32'h4);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_opdec", 32'(bus.op_dec), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_vec", 32'(match_vec), 32'h003);
    check("abort_cnt", 32'(match_count), 2);
    check("abort_any", 32'(any_match), 1);
    count_done(30, pulses);
    check("abort_no_done", 32'(pulses), 0);

    // Start mid-scan is ignored; async reset mid-scan clears everything with no done
    @(negedge clk);
    a_in      = 8'h35;
    id_digits = Ids;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("midstart_opdec_e5", 32'(bus.op_dec), 32'h4);
    @(posedge clk);
    #1;
    check("midstart_opdec_e6", 32'(bus.op_dec), 32'h8);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    count_done(30, pulses);
    check("midreset_no_done", 32'(pulses), 0);
    run_scan("after_reset", 8'h35, Ids);
    check("after_reset_vec", 32'(match_vec), 32'h014);

    // ALU3 returns 4'b0011 on digit 4: match bit set and sticky err until next start
    force_idx = 4;
    run_scan("errscan", 8'hFF, Ids);
    force_idx = -1;
    check("err_vec", 32'(match_vec), 32'h010);
    check("err_cnt", 32'(match_count), 1);
    check("err_flag", 32'(err), 1);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 32'(err), 1);
    @(negedge clk);
    a_in      = 8'hFF;
    id_digits = Ids;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("err_cleared", 32'(err), 0);
    check("vec_cleared", 32'(match_vec), 0);
    count_done(25, pulses);
    check("err_rescan_done", 32'(pulses), 1);
    check("err_rescan_err", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
